// File: rtl/msm_stream.sv
// Streaming MSM engine: R = sum x_i*G_i over pairs fed by valid/ready.
// Point math lives in the mul/add cores; the engine only sequences them.
package msm_pkg;
  typedef struct packed {
    logic        inf;
    logic [63:0] v;
  } curve_point_t;
  localparam curve_point_t INF_POINT = {1'b1, 64'd0};
endpackage

import msm_pkg::*;

module point_mul_double_and_add (
  input  logic         clk,
  input  logic         Reset,
  input  curve_point_t G,
  input  logic [255:0] k,
  output logic         Done,
  output curve_point_t R
);
  logic [63:0]  g_q, acc_q;
  logic [255:0] k_q;
  logic [7:0]   cnt_q;
  logic         done_q;

  // Latch operands on reset, then MSB-first double-and-add, one bit per cycle.
  always_ff @(posedge clk) begin
    if (Reset) begin
      g_q    <= G.inf ? 64'd0 : G.v;
      k_q    <= k;
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      acc_q  <= {acc_q[62:0], 1'b0} + (k_q[255] ? g_q : 64'd0);
      k_q    <= {k_q[254:0], 1'b0};
      cnt_q  <= cnt_q + 8'd1;
      done_q <= (cnt_q == 8'hFF);
    end
  end

  assign Done = done_q;
  assign R    = {(acc_q == 64'd0), acc_q};
endmodule

module point_add (
  input  logic         clk,
  input  logic         Reset,
  input  curve_point_t P,
  input  curve_point_t Q,
  output logic         Done,
  output curve_point_t R
);
  logic [63:0] p_q, q_q, sum;
  logic        done_q;

  // Latch operands on reset; result is ready one cycle later.
  always_ff @(posedge clk) begin
    if (Reset) begin
      p_q    <= P.inf ? 64'd0 : P.v;
      q_q    <= Q.inf ? 64'd0 : Q.v;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b1;
    end
  end

  assign sum  = p_q + q_q;
  assign Done = done_q;
  assign R    = {(sum == 64'd0), sum};
endmodule

module msm_stream #(
  parameter int MAX_TERMS    = 256,
  parameter int SCALAR_W     = 256,
  parameter bit SKIP_TRIVIAL = 1'b1
) (
  input  logic                           clk,
  input  logic                           Reset,
  input  logic                           start,
  input  logic [$clog2(MAX_TERMS+1)-1:0] num_terms,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  curve_point_t                   in_G,
  input  logic [SCALAR_W-1:0]            in_x,
  output logic                           busy,
  output logic                           Done,
  output curve_point_t                   R,
  output logic [$clog2(MAX_TERMS+1)-1:0] term_count
);
  localparam int CW = $clog2(MAX_TERMS+1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MUL_GO, S_MUL_WAIT,
    S_ADD_GO, S_ADD_WAIT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  num_q, num_d, cnt_q, cnt_d;
  curve_point_t   acc_q, acc_d, r_q, r_d, g_q, g_d;
  logic [255:0]   x_q, x_d;
  logic           mul_go, add_go, mul_done, add_done;
  curve_point_t   mul_r, add_r;
  logic [CW-1:0]  num_clamp, cnt_inc;
  logic           trivial;

  assign num_clamp = (num_terms > CW'(MAX_TERMS)) ? CW'(MAX_TERMS)
                                                  : num_terms;
  assign cnt_inc   = cnt_q + CW'(1);
  assign trivial   = SKIP_TRIVIAL && ((in_x == '0) || in_G.inf);

  // Next-state, datapath moves and handshake/core-kick outputs.
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    r_d      = r_q;
    g_d      = g_q;
    x_d      = x_q;
    in_ready = 1'b0;
    mul_go   = 1'b0;
    add_go   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d = '0;
          acc_d = INF_POINT;
          if (num_clamp == '0) begin
            state_d = S_DONE;
            r_d     = INF_POINT;
          end else begin
            state_d = S_FETCH;
            num_d   = num_clamp;
          end
        end
      end
      S_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_inc;
          g_d   = in_G;
          x_d   = 256'(in_x);
          if (!trivial) begin
            state_d = S_MUL_GO;
          end else if (cnt_inc == num_q) begin
            state_d = S_DONE;
            r_d     = acc_q;
          end
        end
      end
      S_MUL_GO: begin
        mul_go  = 1'b1;
        state_d = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mul_done) state_d = S_ADD_GO;
      end
      S_ADD_GO: begin
        add_go  = 1'b1;
        state_d = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        if (add_done) begin
          acc_d = add_r;
          if (cnt_q == num_q) begin
            state_d = S_DONE;
            r_d     = add_r;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= INF_POINT;
      r_q     <= INF_POINT;
      g_q     <= INF_POINT;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      g_q     <= g_d;
      x_q     <= x_d;
    end
  end

  point_mul_double_and_add u_mul (
    .clk  (clk),
    .Reset(Reset | mul_go),
    .G    (g_q),
    .k    (x_q),
    .Done (mul_done),
    .R    (mul_r)
  );

  point_add u_add (
    .clk  (clk),
    .Reset(Reset | add_go),
    .P    (acc_q),
    .Q    (mul_r),
    .Done (add_done),
    .R    (add_r)
  );

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign Done       = (state_q == S_DONE);
  assign R          = r_q;
  assign term_count = cnt_q;
endmodule

// File: tb/tb_msm_stream.sv
// Bench for msm_stream: random jobs vs. a modular-sum reference model.
// The toy group is Z/2^64 with zero represented as the point at infinity.
module tb_msm_stream;
  import msm_pkg::*;

  localparam int CW = 9;
  localparam curve_point_t G1  = {1'b0, 64'h9E37_79B9_7F4A_7C15};
  localparam curve_point_t INF = {1'b1, 64'd0};

  logic         clk = 1'b0;
  logic         Reset, start, in_valid, in_ready, busy, Done;
  logic [CW-1:0] num_terms, term_count;
  curve_point_t in_G, R;
  logic [255:0] in_x;

  int checks = 0;
  int errors = 0;

  curve_point_t g_arr[300];
  logic [255:0] x_arr[300];

  int           lat, consumed;
  int           hs[300];
  bit           tout, seen_ready, viol;
  logic         done1;
  curve_point_t r1;

  msm_stream dut (
    .clk       (clk),
    .Reset     (Reset),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_G      (in_G),
    .in_x      (in_x),
    .busy      (busy),
    .Done      (Done),
    .R         (R),
    .term_count(term_count)
  );

  always #5 clk = ~clk;

  function automatic curve_point_t ref_msm(input int n);
    logic [63:0] acc;
    logic [63:0] gv;
    logic [255:0] xv;
    int m;
    acc = 64'd0;
    m = (n > 256) ? 256 : n;
    for (int i = 0; i < m; i++) begin
      gv = g_arr[i].inf ? 64'd0 : g_arr[i].v;
      xv = x_arr[i];
      acc = acc + gv * xv[63:0];
    end
    return {(acc == 64'd0), acc};
  endfunction

  function automatic curve_point_t rand_pt();
    return {1'b0, $urandom(), $urandom() | 32'd1};
  endfunction

  function automatic logic [255:0] rand_x();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom() | 32'd1};
  endfunction

  task automatic run_job(input int n, input int prob,
                         input int abort_hs, input int abort_dly);
    int  idx, lim, wait_n;
    bit  fire;
    idx = 0; wait_n = 0;
    lim = (n > 256) ? 256 : n;
    seen_ready = 0; viol = 0; tout = 0;
    @(negedge clk);
    start = 1'b1;
    num_terms = n[CW-1:0];
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    done1 = Done;
    r1 = R;
    while (!Done) begin
      if (lat >= 6000) begin
        tout = 1;
        break;
      end
      if (in_ready) seen_ready = 1;
      if (in_ready && (!busy || idx >= lim)) viol = 1;
      if (abort_hs > 0 && idx >= abort_hs) begin
        if (wait_n == abort_dly) begin
          in_valid = 1'b0;
          Reset = 1'b1;
          @(negedge clk);
          Reset = 1'b0;
          consumed = idx;
          return;
        end
        wait_n++;
      end
      in_valid = (idx < lim) && ($urandom_range(99) < prob);
      in_G = g_arr[(idx < 300) ? idx : 0];
      in_x = x_arr[(idx < 300) ? idx : 0];
      fire = in_valid && in_ready;
      @(negedge clk);
      lat++;
      if (fire) begin
        hs[idx] = lat;
        idx++;
      end
    end
    in_valid = 1'b0;
    consumed = idx;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (Done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", Done);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", in_ready);
    end
    checks++;
    if (term_count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", term_count);
    end
    checks++;
    if (R !== INF) begin
      errors++; $display("FAIL reset_R: got %h want %h", R, INF);
    end
  endtask

  task automatic test_two_terms();
    curve_point_t exp_r;
    g_arr[0] = G1; x_arr[0] = 256'd2;
    g_arr[1] = G1; x_arr[1] = 256'd3;
    exp_r = {1'b0, G1.v * 64'd5};
    run_job(2, 100, 0, 0);
    checks++;
    if (tout !== 1'b0) begin
      errors++; $display("FAIL two_timeout: got %b want 0", tout);
    end
    checks++;
    if (R !== exp_r) begin
      errors++; $display("FAIL two_R: got %h want %h", R, exp_r);
    end
    checks++;
    if (term_count !== CW'(2)) begin
      errors++; $display("FAIL two_count: got %0d want 2", term_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL two_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_zero_terms();
    run_job(0, 100, 0, 0);
    checks++;
    if (lat !== 1 || Done !== 1'b1) begin
      errors++; $display("FAIL zero_latency: got %0d/%b want 1/1", lat, Done);
    end
    checks++;
    if (R !== INF) begin
      errors++; $display("FAIL zero_R: got %h want %h", R, INF);
    end
    checks++;
    if ((seen_ready | in_ready) !== 1'b0) begin
      errors++; $display("FAIL zero_ready: got 1 want 0");
    end
  endtask

  task automatic test_skip_trivial();
    g_arr[0] = G1;  x_arr[0] = 256'd0;
    g_arr[1] = INF; x_arr[1] = 256'd7;
    g_arr[2] = G1;  x_arr[2] = 256'd1;
    run_job(3, 100, 0, 0);
    checks++;
    if (R !== G1) begin
      errors++; $display("FAIL skip_R: got %h want %h", R, G1);
    end
    checks++;
    if (hs[1] - hs[0] !== 1) begin
      errors++; $display("FAIL skip_spacing: got %0d want 1", hs[1] - hs[0]);
    end
    checks++;
    if (consumed !== 3 || term_count !== CW'(3)) begin
      errors++;
      $display("FAIL skip_count: got %0d/%0d want 3", consumed, term_count);
    end
  endtask

  task automatic test_all_trivial_clamp();
    for (int i = 0; i < 300; i++) begin
      g_arr[i] = G1;
      x_arr[i] = 256'd0;
    end
    run_job(5, 100, 0, 0);
    checks++;
    if (lat !== 6 || R !== INF) begin
      errors++; $display("FAIL trivial5: got lat %0d R %h want 6 %h", lat, R, INF);
    end
    run_job(300, 100, 0, 0);
    checks++;
    if (lat !== 257 || term_count !== CW'(256) || consumed !== 256) begin
      errors++;
      $display("FAIL clamp: got lat %0d cnt %0d used %0d want 257 256 256",
               lat, term_count, consumed);
    end
  endtask

  task automatic test_random_stream();
    curve_point_t exp_r;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 4; i++) begin
        g_arr[i] = ($urandom_range(9) == 0) ? INF : rand_pt();
        x_arr[i] = ($urandom_range(9) == 0) ? 256'd0 : rand_x();
      end
      exp_r = ref_msm(4);
      run_job(4, 50, 0, 0);
      checks++;
      if (R !== exp_r || tout !== 1'b0) begin
        errors++; $display("FAIL rand_R[%0d]: got %h want %h", rep, R, exp_r);
      end
      checks++;
      if (term_count !== CW'(4) || consumed !== 4) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d/%0d want 4", rep, term_count, consumed);
      end
      checks++;
      if (viol !== 1'b0) begin
        errors++; $display("FAIL rand_ready[%0d]: got 1 want 0", rep);
      end
    end
  endtask

  task automatic test_reset_mid();
    curve_point_t exp_r;
    for (int i = 0; i < 3; i++) begin
      g_arr[i] = rand_pt();
      x_arr[i] = rand_x();
    end
    run_job(3, 100, 2, 20);
    checks++;
    if (busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL mid_flags: got %b%b want 00", busy, Done);
    end
    checks++;
    if (R !== INF || term_count !== '0) begin
      errors++;
      $display("FAIL mid_state: got %h/%0d want %h/0", R, term_count, INF);
    end
    exp_r = ref_msm(3);
    run_job(3, 70, 0, 0);
    checks++;
    if (R !== exp_r || term_count !== CW'(3)) begin
      errors++; $display("FAIL mid_fresh: got %h want %h", R, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    curve_point_t old_r;
    old_r = R;
    checks++;
    if (Done !== 1'b1) begin
      errors++; $display("FAIL b2b_pre: got %b want 1", Done);
    end
    g_arr[0] = G1; x_arr[0] = 256'd1;
    run_job(1, 100, 0, 0);
    checks++;
    if (done1 !== 1'b0 || r1 !== old_r) begin
      errors++;
      $display("FAIL b2b_drop: got %b %h want 0 %h", done1, r1, old_r);
    end
    checks++;
    if (Done !== 1'b1 || R !== G1) begin
      errors++; $display("FAIL b2b_R: got %b %h want 1 %h", Done, R, G1);
    end
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    num_terms = '0;
    in_G = INF;
    in_x = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    test_reset();
    test_two_terms();
    test_zero_terms();
    test_skip_trivial();
    test_all_trivial_clamp();
    test_random_stream();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/msm_stream.md
Name: msm_stream

Overview:
- Parametrised, streaming successor to the fixed-array naive MSM engine.
- Computes R = sum over i of x_i·G_i for a runtime-selected number of terms, 0..MAX_TERMS.
- (G_i, x_i) pairs arrive one at a time over a valid/ready handshake, so no full point/scalar arrays are needed at the port boundary.
- Sits between the host-side operand feeder and the existing point_mul_double_and_add / point_add cores. One instance of each core is used, driven sequentially.

Parameters:
- MAX_TERMS, 256, largest term count accepted per job.
- SCALAR_W, 256, scalar width. Must be ≤256; zero-extended to 256 bits before reaching the multiplier k input.
- SKIP_TRIVIAL, 1, when 1, terms with x_i==0 or G_i==inf_point bypass mul and add.

Ports:
- clk, input, 1, system clock.
- Reset, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a job when idle.
- num_terms, input, $clog2(MAX_TERMS+1), term count; sampled on accepted start.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, engine can accept a pair this cycle.
- in_G, input, curve_point_t, base point G_i.
- in_x, input, SCALAR_W, scalar x_i.
- busy, output, 1, job in progress (start accepted, Done not yet raised).
- Done, output, 1, result valid; held until next accepted start or Reset.
- R, output, curve_point_t, accumulated sum.
- term_count, output, $clog2(MAX_TERMS+1), pairs consumed in the current job.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - State=IDLE; busy=0, Done=0, in_ready=0, term_count=0, R=inf_point.
  - Both core resets are asserted for that cycle, so any core in flight is abandoned.
- Core contract: a core's Reset held high for one cycle latches its operands. Its Done is a level, valid until that core's next Reset. The engine pulses each core reset for exactly one cycle per use.
- States:
  - IDLE: in_ready=0.
    - start=1 with num_terms==0 → DONE next cycle, R=inf_point.
    - start=1 with num_terms>0 → FETCH; latch num_terms; accumulator=inf_point; Done←0; busy←1; term_count←0.
    - start while busy is ignored.
  - FETCH: in_ready=1. Handshake fires when in_valid&&in_ready; latch in_G and zero-extended in_x, term_count+1.
    - Trivial pair (SKIP_TRIVIAL=1 and (x==0 or G==inf_point)): last term → DONE, else stay in FETCH. No core activity.
    - Otherwise → MUL_GO.
  - MUL_GO: mul reset=1 for one cycle → MUL_WAIT.
  - MUL_WAIT: when mul Done → ADD_GO. add P=accumulator, Q=mul result.
  - ADD_GO: add reset=1 for one cycle → ADD_WAIT.
  - ADD_WAIT: when add Done → accumulator←add result.
    - term_count==num_terms → DONE, else → FETCH.
  - DONE: R=accumulator; Done=1; busy=0; in_ready=0. Accepted start → same behaviour as from IDLE.
- Timing rules:
  - in_ready is never asserted outside FETCH.
  - At most one pair is consumed per job slot; excess in_valid is held off, never dropped.
  - in_valid may drop at any time in FETCH; the engine waits indefinitely.
- R register is updated only on entry to DONE. R is stable whenever Done=1.
- Minimum overhead per non-trivial term, beyond core latencies: 1 handshake + 1 MUL_GO + 1 ADD_GO cycle.
- Minimum per trivial term: 1 cycle.
- Latency, start to Done:
  - num_terms==0: 1 cycle.
  - all-trivial job of N terms with in_valid held high: N+1 cycles.
- Arithmetic: all point math is delegated to the cores; the engine only moves curve_point_t values. num_terms>MAX_TERMS is clamped to MAX_TERMS.
- Simultaneous events: Reset dominates start and in_valid. A start arriving in the same cycle that Done rises is ignored.

Test Plan:
- start, num_terms=2, pairs (G1,2),(G1,3), G1=curve generator → Done=1, R equals golden 5·G1, term_count=2, busy low on the Done cycle.
- start, num_terms=0 → Done=1 exactly 1 cycle after start, R=inf_point, in_ready never asserted.
- SKIP_TRIVIAL=1, num_terms=3, pairs (G1,0),(inf_point,7),(G1,1) → R=G1; no core reset during the first two terms; first two handshakes 1 cycle apart.
- num_terms=4, random G/x, in_valid toggled 50% random → R matches golden sum; in_ready low outside FETCH; no pair lost or duplicated (term_count=4).
- Reset asserted mid MUL_WAIT of term 2 of 3 → next cycle busy=0, Done=0, R=inf_point, term_count=0. A fresh job then completes correctly.
- In DONE, a new start with num_terms=1, pair (G1,1) → Done drops next cycle, then rises with R=G1. Previous R is held until Done drops.
